// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg
//   Shared definitions for the 7-segment scan controller:
//   FSM state encodings, default digit count, blank code
//   and a small compile-time max helper for sizing counters.
package seg_scan_ctrl_pkg;

    typedef enum logic {
        S_GAP  = 1'b0,
        S_SHOW = 1'b1
    } seg_state_e;

    localparam int         SEG_NDIG  = 8;
    localparam logic [3:0] SEG_BLANK = 4'hF;

    function automatic int seg_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit 7-segment display.
//   Once per frame (on entry to digit 0) it snapshots the digit data,
//   the enable mask and the FIFO front index, then walks the digits.
//   Each digit slot is GAP cycles with all anodes off followed by DIV
//   cycles with that digit's anode driven low (if enabled).
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   data[4N-1:0]   : BCD nibbles, digit i = data[4i+3:4i]
//   mask[N-1:0]    : 1 = digit shown, 0 = blanked
//   front_in[2:0]  : FIFO front index
//   x[3:0]         : BCD code to decoder, 4'hF when blanked
//   num[2:0]       : current digit index to decoder
//   front[2:0]     : frame snapshot of front_in
//   an[N-1:0]      : active-low anodes (one low, or all high)
//   frame_start    : one-cycle pulse when a new snapshot takes effect
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NDIG = SEG_NDIG,
    parameter int DIV  = 100000,
    parameter int GAP  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] data,
    input  logic [NDIG-1:0]   mask,
    input  logic [2:0]        front_in,
    output logic [3:0]        x,
    output logic [2:0]        num,
    output logic [2:0]        front,
    output logic [NDIG-1:0]   an,
    output logic              frame_start
);

    localparam int CNT_MAX = seg_max(DIV, GAP);
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [2:0]    DIG_LAST  = 3'(NDIG - 1);
    localparam logic [NDIG-1:0] AN_OFF  = '1;

    seg_state_e        r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_digit;
    logic [4*NDIG-1:0] r_data_q;
    logic [NDIG-1:0]   r_mask_q;

    // At digit 0 the snapshot is being reloaded on this very edge, so the
    // outputs must come straight from the inputs rather than the stale copy.
    logic [4*NDIG-1:0] w_data_eff;
    logic [NDIG-1:0]   w_mask_eff;
    logic [3:0]        w_nib;
    logic              w_lit;
    logic [NDIG-1:0]   w_an_lit;

    always_comb begin
        w_data_eff = (r_digit == 3'd0) ? data : r_data_q;
        w_mask_eff = (r_digit == 3'd0) ? mask : r_mask_q;
        w_nib      = w_data_eff[4*r_digit +: 4];
        w_lit      = w_mask_eff[r_digit];
        w_an_lit   = ~(NDIG'(1) << r_digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_GAP;
            r_cnt       <= '0;
            r_digit     <= 3'd0;
            r_data_q    <= '0;
            r_mask_q    <= '0;
            front       <= 3'd0;
            an          <= AN_OFF;
            x           <= SEG_BLANK;
            num         <= 3'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (r_state)
                S_GAP: begin
                    an <= AN_OFF;
                    if (r_cnt == GAP_LAST) begin
                        r_state <= S_SHOW;
                        r_cnt   <= '0;
                        num     <= r_digit;
                        x       <= w_lit ? w_nib : SEG_BLANK;
                        an      <= w_lit ? w_an_lit : AN_OFF;
                        if (r_digit == 3'd0) begin
                            r_data_q    <= data;
                            r_mask_q    <= mask;
                            front       <= front_in;
                            frame_start <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (r_cnt == DIV_LAST) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                        an      <= AN_OFF;
                        r_digit <= (r_digit == DIG_LAST) ? 3'd0 : r_digit + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Directed + randomized bench for seg_scan_ctrl with DIV=4, GAP=2.
//   The reference model works from elapsed cycles since reset: each digit
//   slot is 6 cycles (2 off, 4 lit), each frame 8 slots.
module tb_seg_scan_ctrl;

    localparam int DIVP  = 4;
    localparam int GAPP  = 2;
    localparam int SLOT  = DIVP + GAPP;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  mask;
    logic [2:0]  front_in;
    logic [3:0]  x;
    logic [2:0]  num;
    logic [2:0]  front;
    logic [7:0]  an;
    logic        frame_start;

    seg_scan_ctrl #(.NDIG(8), .DIV(DIVP), .GAP(GAPP)) dut (
        .clk(clk), .rst(rst), .data(data), .mask(mask), .front_in(front_in),
        .x(x), .num(num), .front(front), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          k;        // edges since reset released (0 = reset edge)
    int          cyc = 0;
    int          last_fs = -1;
    logic [31:0] m_data;
    logic [7:0]  m_mask;
    logic [2:0]  m_front;
    logic [3:0]  last_x;
    logic [2:0]  last_num;
    int          p, d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic [7:0] e_an;
        logic [3:0] e_x;
        logic [2:0] e_num;
        logic       e_fs;
        logic       lit;
        logic [7:0] one;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            k = 0; p = 0; d = 0;
            m_data = '0; m_mask = '0; m_front = '0;
            last_x = 4'hF; last_num = 3'd0;
            e_an = 8'hFF; e_x = 4'hF; e_num = 3'd0; e_fs = 1'b0;
            last_fs = -1;
        end else begin
            k++;
            p = k % SLOT;
            d = (k / SLOT) % 8;
            if (p == GAPP && d == 0) begin
                m_data = data; m_mask = mask; m_front = front_in;
            end
            lit = m_mask[d];
            if (p == GAPP) begin
                last_x   = lit ? m_data[4*d +: 4] : 4'hF;
                last_num = 3'(d);
            end
            one  = 8'd1 << d;
            e_an = (p >= GAPP && lit) ? ~one : 8'hFF;
            e_x  = last_x;
            e_num = last_num;
            e_fs = (p == GAPP && d == 0);
        end
        chk("an", 32'(an), 32'(e_an));
        chk("x", 32'(x), 32'(e_x));
        chk("num", 32'(num), 32'(e_num));
        chk("front", 32'(front), 32'(m_front));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
        for (int i = 0; i < 8; i++)
            if (an[i] == 1'b0) chk("lit_masked", 32'(m_mask[i]), 32'd1);
        if (frame_start) begin
            if (last_fs >= 0) chk("fs_spacing", 32'(cyc - last_fs), 32'(FRAME));
            last_fs = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; data = '0; mask = '0; front_in = '0;
        run(3);
        // first frame: ascending digits, all shown
        rst = 1'b0; data = 32'h76543210; mask = 8'hFF; front_in = 3'd2;
        run(FRAME + 4);
        // upper digits blanked
        mask = 8'h0F;
        run(FRAME);
        mask = 8'hFF;
        // wait for digit 3 lit, then change inputs mid-frame
        for (int n = 0; n < 2*FRAME && !(d == 3 && p == GAPP + 1); n++) step();
        chk("wait_d3", 32'(d == 3 && p == GAPP + 1), 32'd1);
        data = 32'h99999999; front_in = 3'd5;
        run(FRAME + 12);
        // randomized input churn, arbitrary change points
        for (int f = 0; f < 5 * FRAME; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                data = $urandom; mask = 8'($urandom); front_in = 3'($urandom);
            end
            step();
        end
        // reset during SHOW of digit 5
        for (int n = 0; n < 2*FRAME && !(d == 5 && p == GAPP + 1); n++) step();
        chk("wait_d5", 32'(d == 5 && p == GAPP + 1), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; data = $urandom; mask = 8'($urandom) | 8'h01; front_in = 3'($urandom);
        run(GAPP);
        chk("restart_d0_lit", 32'(an), 32'h000000FE);
        // three frames of random masks, invariants checked every cycle
        for (int f = 0; f < 3 * FRAME; f++) begin
            if ((f % 17) == 5) begin
                data = $urandom; mask = 8'($urandom);
            end
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
